// File: rtl/gate_truth_checker_pkg.sv
// Shared encodings and truth-table constants for the gate truth-table checker.
package gate_check_pkg;

  localparam int NUM_VECTORS = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2
  } state_t;

  // Truth tables are indexed by {a,b}: bit 0 is a=0,b=0.
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/gate_truth_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      count <= '0;
    else if (clear)                 count <= '0;
    else if (enable && count != '1) count <= count + W'(1);
  end

endmodule

// File: rtl/gate_truth_checker.sv
// Sweeps a 2-input gate through all four input vectors, samples y after a
// settle interval and accumulates mismatches against TRUTH_TABLE.
module gate_truth_checker
  import gate_check_pkg::*;
#(
  parameter logic [3:0] TRUTH_TABLE   = TT_NAND,
  parameter int         SETTLE_CYCLES = 2,
  parameter int         PASSES        = 1,
  parameter int         ERR_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_vec
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int SW = (PASSES > 1) ? $clog2(PASSES + 1) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0] SWEEP_LAST  = SW'(PASSES - 1);

  state_t        state, state_nxt;
  logic [1:0]    idx;
  logic [SW-1:0] sweep;
  logic [CW-1:0] settle_cnt;
  logic          accept, sample, mismatch, last;

  assign accept   = (state == ST_IDLE) && start;
  assign sample   = (state == ST_SAMPLE);
  // Case inequality so an undriven or X output counts as a failure.
  assign mismatch = (y !== TRUTH_TABLE[idx]);
  assign last     = (idx == 2'd3) && (sweep == SWEEP_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_SETTLE;
      ST_SETTLE: if (settle_cnt == SETTLE_LAST) state_nxt = ST_SAMPLE;
      ST_SAMPLE: state_nxt = last ? ST_IDLE : ST_SETTLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx        <= '0;
      sweep      <= '0;
      settle_cnt <= '0;
      a          <= 1'b0;
      b          <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_vec   <= '0;
    end else if (accept) begin
      idx        <= '0;
      sweep      <= '0;
      settle_cnt <= '0;
      a          <= 1'b0;
      b          <= 1'b0;
      busy       <= 1'b1;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_vec   <= '0;
    end else if (state == ST_SETTLE) begin
      settle_cnt <= settle_cnt + CW'(1);
    end else if (sample) begin
      if (mismatch) fail_vec[idx] <= 1'b1;
      if (last) begin
        busy <= 1'b0;
        done <= 1'b1;
        // A saturating count can never return to zero, so this equals the updated count being zero.
        pass <= (err_count == '0) && !mismatch;
      end else begin
        idx        <= idx + 2'd1;
        {a, b}     <= idx + 2'd1;
        settle_cnt <= '0;
        if (idx == 2'd3) sweep <= sweep + SW'(1);
      end
    end
  end

  sat_counter #(.W(ERR_W)) u_err (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .enable (sample && mismatch),
    .count  (err_count)
  );

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed and random-table runs of four checker configurations against a
// table-level model of the expected sweep outcome.
module tb_gate_truth_checker;
  import gate_check_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       start_s [4];
  logic       a_v [4], b_v [4], y_v [4];
  logic       busy_v [4], done_v [4], pass_v [4];
  logic [3:0] fv [4];
  logic [7:0] ec [4];
  logic [5:0] ec3;
  logic [3:0] tab [4];

  int tt_p  [4] = '{TT_NAND, TT_AND, TT_NAND, TT_NAND};
  int pas_p [4] = '{1, 1, 100, 100};
  int set_p [4] = '{2, 2, 1, 1};
  int ew_p  [4] = '{8, 8, 8, 6};

  int total = 0;
  int bad   = 0;

  // Each behavioural gate is just a lookup of its own function table.
  for (genvar i = 0; i < 4; i++) begin : g_y
    assign y_v[i] = tab[i][{a_v[i], b_v[i]}];
  end
  assign ec[3] = {2'b00, ec3};

  gate_truth_checker #(.TRUTH_TABLE(TT_NAND), .SETTLE_CYCLES(2), .PASSES(1), .ERR_W(8)) u0 (
    .clk(clk), .reset(reset), .start(start_s[0]), .a(a_v[0]), .b(b_v[0]), .y(y_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(ec[0]), .fail_vec(fv[0]));
  gate_truth_checker #(.TRUTH_TABLE(TT_AND), .SETTLE_CYCLES(2), .PASSES(1), .ERR_W(8)) u1 (
    .clk(clk), .reset(reset), .start(start_s[1]), .a(a_v[1]), .b(b_v[1]), .y(y_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(ec[1]), .fail_vec(fv[1]));
  gate_truth_checker #(.TRUTH_TABLE(TT_NAND), .SETTLE_CYCLES(1), .PASSES(100), .ERR_W(8)) u2 (
    .clk(clk), .reset(reset), .start(start_s[2]), .a(a_v[2]), .b(b_v[2]), .y(y_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_count(ec[2]), .fail_vec(fv[2]));
  gate_truth_checker #(.TRUTH_TABLE(TT_NAND), .SETTLE_CYCLES(1), .PASSES(100), .ERR_W(6)) u3 (
    .clk(clk), .reset(reset), .start(start_s[3]), .a(a_v[3]), .b(b_v[3]), .y(y_v[3]),
    .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3]), .err_count(ec3), .fail_vec(fv[3]));

  task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s dut=%0d got=%0h exp=%0h", tag, k, got, exp);
    end
  endtask

  // One full run on instance k with gate table t; poke re-pulses start while
  // busy and on the done edge, both of which must be ignored.
  task automatic run(input int k, input logic [3:0] t, input bit poke);
    int n, lat, e;
    logic [3:0] efv;
    tab[k] = t;
    efv = t ^ 4'(tt_p[k]);
    e = pas_p[k] * $countones(efv);
    if (e > (1 << ew_p[k]) - 1) e = (1 << ew_p[k]) - 1;
    lat = 4 * pas_p[k] * (set_p[k] + 1);
    @(negedge clk); start_s[k] = 1'b1;
    @(negedge clk); start_s[k] = 1'b0;
    chk("busy_start", k, 32'(busy_v[k]), 1);
    chk("done_clr",   k, 32'(done_v[k]), 0);
    chk("err_clr",    k, 32'(ec[k]), 0);
    n = 0;
    while (!done_v[k] && n < lat + 50) begin
      start_s[k] = poke && (n == 3 || n == lat - 1);
      @(negedge clk);
      n++;
    end
    start_s[k] = 1'b0;
    chk("latency",  k, n, lat);
    chk("pass",     k, 32'(pass_v[k]), 32'(e == 0));
    chk("err",      k, 32'(ec[k]), e);
    chk("fail_vec", k, 32'(fv[k]), 32'(efv));
    chk("busy_end", k, 32'(busy_v[k]), 0);
    chk("ab_last",  k, 32'({a_v[k], b_v[k]}), 3);
    if (poke) begin
      @(negedge clk);
      chk("done_hold", k, 32'(done_v[k]), 1);
      chk("busy_hold", k, 32'(busy_v[k]), 0);
      chk("err_hold",  k, 32'(ec[k]), e);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      start_s[k] = 1'b0;
      tab[k] = TT_NAND;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("rst_ab",   k, 32'({a_v[k], b_v[k]}), 0);
      chk("rst_busy", k, 32'(busy_v[k]), 0);
      chk("rst_done", k, 32'(done_v[k]), 0);
      chk("rst_pass", k, 32'(pass_v[k]), 0);
      chk("rst_err",  k, 32'(ec[k]), 0);
      chk("rst_fv",   k, 32'(fv[k]), 0);
    end
    reset = 1'b0;

    run(0, TT_NAND, 1'b1);
    run(0, TT_NAND, 1'b0);
    run(1, TT_NAND, 1'b0);
    run(0, 4'b0000, 1'b0);
    run(2, 4'b1111, 1'b0);
    run(3, 4'b1111, 1'b0);
    repeat (6) begin
      run(0, 4'($urandom), 1'b0);
      run(1, 4'($urandom), 1'b0);
    end
    run(2, 4'($urandom), 1'b0);

    // Abort a run while vector {a,b}=10 is settling.
    tab[0] = TT_OR;
    @(negedge clk); start_s[0] = 1'b1;
    @(negedge clk); start_s[0] = 1'b0;
    n = 0;
    while (!(a_v[0] && !b_v[0]) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reach_vec2", 0, 32'(n < 50), 1);
    reset = 1'b1;
    #1;
    chk("abort_ab",   0, 32'({a_v[0], b_v[0]}), 0);
    chk("abort_busy", 0, 32'(busy_v[0]), 0);
    chk("abort_done", 0, 32'(done_v[0]), 0);
    chk("abort_err",  0, 32'(ec[0]), 0);
    @(negedge clk); reset = 1'b0;
    run(0, TT_NAND, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
